// File: rtl/setup_study_board.sv
// ============================================================================
// Module   : setup_study_board
// Summary  : DFF setup-time characterization model with a min-margin table
//            indexed by (data edge, clock slope, data slope).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module setup_study_board #(
    parameter int unsigned SU_BASE   = 30,
    parameter int unsigned CK_SHIFT  = 4,
    parameter int unsigned D_SHIFT   = 3,
    parameter int unsigned CQ_BASE   = 400,
    parameter int unsigned CAP_SHIFT = 5,
    parameter int unsigned SLOPE0    = 12,
    parameter int unsigned SLOPE1    = 449,
    parameter int unsigned SLOPE2    = 1985
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic [7:0]  setup_margin,
    input  logic [1:0]  tt_clk_sel,
    input  logic [1:0]  tt_d_sel,
    input  logic [15:0] cap_load,
    input  logic        fin_test,
    output logic        q,
    output logic        setup_pass,
    output logic [7:0]  setup_req,
    output logic [15:0] cq_delay,
    input  logic        rd_edge,
    input  logic [1:0]  rd_ck,
    input  logic [1:0]  rd_d,
    output logic [7:0]  rd_data
);

    localparam logic [15:0] c_SLOPE0   = 16'(SLOPE0);
    localparam logic [15:0] c_SLOPE1   = 16'(SLOPE1);
    localparam logic [15:0] c_SLOPE2   = 16'(SLOPE2);
    localparam logic [7:0]  c_NEVER    = 8'hFF;
    localparam logic [15:0] c_REQ_SAT  = 16'd255;
    localparam logic [17:0] c_CQ_SAT   = 18'd65535;

    // Select value 3 is not a real slope point; it folds onto index 2.
    function automatic logic [1:0] fold_idx(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd2 : sel;
    endfunction

    function automatic logic [15:0] slope_of(input logic [1:0] idx);
        logic [15:0] v;
        case (idx)
            2'd0:    v = c_SLOPE0;
            2'd1:    v = c_SLOPE1;
            default: v = c_SLOPE2;
        endcase
        return v;
    endfunction

    logic [1:0]  w_ck_idx;
    logic [1:0]  w_d_idx;
    logic [1:0]  w_rd_ck_idx;
    logic [1:0]  w_rd_d_idx;
    logic [15:0] w_ck_term;
    logic [15:0] w_d_term;
    logic [15:0] w_req_sum;
    logic [17:0] w_cq_sum;
    logic        w_pass;
    logic        w_edge;
    logic [7:0]  w_cur_entry;
    logic        w_upd;

    logic        r_q;
    logic        r_pass;
    logic [7:0]  r_tab [0:1][0:2][0:2];

    assign w_ck_idx    = fold_idx(tt_clk_sel);
    assign w_d_idx     = fold_idx(tt_d_sel);
    assign w_rd_ck_idx = fold_idx(rd_ck);
    assign w_rd_d_idx  = fold_idx(rd_d);

    assign w_ck_term = slope_of(w_ck_idx) >> CK_SHIFT;
    assign w_d_term  = slope_of(w_d_idx) >> D_SHIFT;

    // Sum is kept wide so the clamp sees the true value, not a wrapped one.
    assign w_req_sum = 16'(SU_BASE) + w_ck_term + w_d_term;
    assign setup_req = (w_req_sum > c_REQ_SAT) ? c_NEVER : w_req_sum[7:0];

    assign w_cq_sum = 18'(CQ_BASE) + 18'(cap_load >> CAP_SHIFT) + 18'(w_ck_term);
    assign cq_delay = (w_cq_sum > c_CQ_SAT) ? 16'hFFFF : w_cq_sum[15:0];

    assign w_pass = (setup_margin >= setup_req);

    // A captured 1 is a rising data transition (table 0), a captured 0 falling.
    assign w_edge      = ~din;
    assign w_cur_entry = r_tab[w_edge][w_ck_idx][w_d_idx];
    assign w_upd       = ~fin_test && w_pass && (din != r_q)
                         && (setup_margin < w_cur_entry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_pass <= w_pass;
            if (w_pass) begin
                r_q <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                for (int c = 0; c < 3; c++) begin
                    for (int d = 0; d < 3; d++) begin
                        r_tab[e][c][d] <= c_NEVER;
                    end
                end
            end
        end else if (w_upd) begin
            r_tab[w_edge][w_ck_idx][w_d_idx] <= setup_margin;
        end
    end

    assign q          = r_q;
    assign setup_pass = r_pass;
    assign rd_data    = r_tab[rd_edge][w_rd_ck_idx][w_rd_d_idx];

endmodule

`default_nettype wire

// File: tb/tb_setup_study_board.sv
// ============================================================================
// Module   : tb_setup_study_board
// Summary  : Directed bench for setup_study_board: requirement/cq vectors,
//            boundary capture, descending-margin sweep, freeze and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_setup_study_board;

    logic        clk;
    logic        rst;
    logic        din;
    logic [7:0]  setup_margin;
    logic [1:0]  tt_clk_sel;
    logic [1:0]  tt_d_sel;
    logic [15:0] cap_load;
    logic        fin_test;
    logic        q;
    logic        setup_pass;
    logic [7:0]  setup_req;
    logic [15:0] cq_delay;
    logic        rd_edge;
    logic [1:0]  rd_ck;
    logic [1:0]  rd_d;
    logic [7:0]  rd_data;

    int total = 0;
    int bad   = 0;

    setup_study_board dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .setup_margin (setup_margin),
        .tt_clk_sel   (tt_clk_sel),
        .tt_d_sel     (tt_d_sel),
        .cap_load     (cap_load),
        .fin_test     (fin_test),
        .q            (q),
        .setup_pass   (setup_pass),
        .setup_req    (setup_req),
        .cq_delay     (cq_delay),
        .rd_edge      (rd_edge),
        .rd_ck        (rd_ck),
        .rd_d         (rd_d),
        .rd_data      (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ck;
        logic [1:0]  d;
        logic [15:0] cap;
        logic [7:0]  req;
        logic [15:0] cq;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic e, input logic [1:0] c, input logic [1:0] d,
                          input logic [7:0] exp, input string nm);
        rd_edge = e;
        rd_ck   = c;
        rd_d    = d;
        #1;
        chk(nm, rd_data, exp);
    endtask

    initial begin
        logic exp_q;

        rst = 1'b1; din = 1'b0; setup_margin = 8'd0; tt_clk_sel = 2'd0; tt_d_sel = 2'd0;
        cap_load = 16'd0; fin_test = 1'b0; rd_edge = 1'b0; rd_ck = 2'd0; rd_d = 2'd0;

        //               ck    d     cap        req     cq
        vecs[0]  = '{2'd0, 2'd0, 16'd0,     8'd31,  16'd400};
        vecs[1]  = '{2'd0, 2'd1, 16'd31,    8'd86,  16'd400};
        vecs[2]  = '{2'd0, 2'd2, 16'd6073,  8'd255, 16'd589};
        vecs[3]  = '{2'd1, 2'd0, 16'd0,     8'd59,  16'd428};
        vecs[4]  = '{2'd1, 2'd1, 16'd32,    8'd114, 16'd429};
        vecs[5]  = '{2'd1, 2'd2, 16'd0,     8'd255, 16'd428};
        vecs[6]  = '{2'd2, 2'd0, 16'd0,     8'd155, 16'd524};
        vecs[7]  = '{2'd2, 2'd1, 16'd65535, 8'd210, 16'd2571};
        vecs[8]  = '{2'd2, 2'd2, 16'd0,     8'd255, 16'd524};
        vecs[9]  = '{2'd3, 2'd0, 16'd32,    8'd155, 16'd525};
        vecs[10] = '{2'd0, 2'd3, 16'd0,     8'd255, 16'd400};
        vecs[11] = '{2'd3, 2'd3, 16'd100,   8'd255, 16'd527};
        vecs[12] = '{2'd1, 2'd3, 16'd6073,  8'd255, 16'd617};

        step();
        step();
        chk("rst_q", q, 0);
        chk("rst_pass", setup_pass, 0);
        for (int e = 0; e < 2; e++)
            for (int c = 0; c < 3; c++)
                for (int d = 0; d < 3; d++)
                    rd_chk(e[0], 2'(c), 2'(d), 8'd255, "rst_tab");

        // Combinational vectors while reset holds the registers still.
        for (int i = 0; i < 13; i++) begin
            tt_clk_sel = vecs[i].ck;
            tt_d_sel   = vecs[i].d;
            cap_load   = vecs[i].cap;
            #1;
            chk("setup_req", setup_req, vecs[i].req);
            chk("cq_delay", cq_delay, vecs[i].cq);
        end

        tt_clk_sel = 2'd0; tt_d_sel = 2'd0; cap_load = 16'd0;
        rst = 1'b0;

        // Boundary: margin one below requirement fails and holds q.
        din = 1'b1; setup_margin = 8'd30;
        step();
        chk("bnd30_q", q, 0);
        chk("bnd30_pass", setup_pass, 0);
        setup_margin = 8'd0;
        rd_chk(1'b0, 2'd0, 2'd0, 8'd255, "bnd30_tab");

        setup_margin = 8'd31;
        rd_chk(1'b0, 2'd0, 2'd0, 8'd255, "bnd31_pre");
        step();
        chk("bnd31_q", q, 1);
        chk("bnd31_pass", setup_pass, 1);
        setup_margin = 8'd0;
        rd_chk(1'b0, 2'd0, 2'd0, 8'd31, "bnd31_tab");
        rd_chk(1'b1, 2'd0, 2'd0, 8'd255, "bnd31_fall");

        // Passing capture with no transition must not touch the table.
        tt_d_sel = 2'd1; din = 1'b1; setup_margin = 8'd200;
        step();
        chk("notr_pass", setup_pass, 1);
        setup_margin = 8'd0;
        rd_chk(1'b0, 2'd0, 2'd1, 8'd255, "notr_tab");

        // Falling capture at clock slope select 3, read back through both aliases.
        tt_clk_sel = 2'd3; tt_d_sel = 2'd0; din = 1'b0; setup_margin = 8'd160;
        step();
        chk("alias_q", q, 0);
        setup_margin = 8'd0;
        rd_chk(1'b1, 2'd2, 2'd0, 8'd160, "alias_rd2");
        rd_chk(1'b1, 2'd3, 2'd0, 8'd160, "alias_rd3");

        // Sweep: each margin gets a rising then a falling attempt.
        tt_clk_sel = 2'd1; tt_d_sel = 2'd0;
        exp_q = 1'b0;
        for (int m = 100; m >= 0; m--) begin
            for (int k = 0; k < 2; k++) begin
                din = (k == 0);
                setup_margin = 8'(m);
                step();
                if (m >= 59) exp_q = (k == 0);
                chk("sweep_q", q, exp_q);
                chk("sweep_pass", setup_pass, (m >= 59));
            end
        end
        setup_margin = 8'd0;
        rd_chk(1'b0, 2'd1, 2'd0, 8'd59, "sweep_rise");
        rd_chk(1'b1, 2'd1, 2'd0, 8'd59, "sweep_fall");

        // Freeze: q keeps following din, table stays as it was.
        fin_test = 1'b1; tt_clk_sel = 2'd0; tt_d_sel = 2'd0;
        din = 1'b1; setup_margin = 8'd40;
        step();
        chk("frz_q1", q, 1);
        chk("frz_pass", setup_pass, 1);
        din = 1'b0;
        step();
        chk("frz_q0", q, 0);
        setup_margin = 8'd0;
        rd_chk(1'b0, 2'd0, 2'd0, 8'd31, "frz_rise");
        rd_chk(1'b1, 2'd0, 2'd0, 8'd255, "frz_fall");

        // Reset wins over a passing transition on the same edge.
        fin_test = 1'b0; rst = 1'b1; din = 1'b1; setup_margin = 8'd200;
        step();
        chk("midrst_q", q, 0);
        chk("midrst_pass", setup_pass, 0);
        rst = 1'b0; setup_margin = 8'd0; din = 1'b0;
        rd_chk(1'b0, 2'd0, 2'd0, 8'd255, "midrst_tab");
        rd_chk(1'b0, 2'd1, 2'd0, 8'd255, "midrst_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/setup_study_board.md
Name: setup_study_board

Overview:
Synthesizable digital model of a D flip-flop setup-time characterization board.
- Each clk rising edge, the block samples din through a modelled DFF. The capture succeeds only if the declared data setup margin meets a slope-dependent setup requirement.
- The block records, per (data edge, clock slope, data slope) point, the smallest passing margin in an 18-entry result table.
- It sits between the sweep sequencer (drives din, margin, slope indices, load) and the result readout logic.

Parameters:
SU_BASE, 30, base setup requirement in steps (1 step = 0.1 ps)
CK_SHIFT, 4, clock-slope contribution = slope_steps >> CK_SHIFT
D_SHIFT, 3, data-slope contribution = slope_steps >> D_SHIFT
CQ_BASE, 400, base clock-to-q estimate in steps
CAP_SHIFT, 5, load contribution = cap_load >> CAP_SHIFT
SLOPE0/SLOPE1/SLOPE2, 12/449/1985, slope values in steps for indices 0/1/2

Ports:
clk  in  1  single clock, rising edge active
rst  in  1  synchronous, active-high reset
din  in  1  data presented to the modelled DFF
setup_margin  in  8  time din was stable before this edge, in steps (0..255)
tt_clk_sel  in  2  clock slope index 0..2 (3 treated as 2)
tt_d_sel  in  2  data slope index 0..2 (3 treated as 2)
cap_load  in  16  load capacitance, 0.01 fF units (e.g. 6073 = 60.73 fF)
fin_test  in  1  end of sweep: freezes table updates
q  out  1  modelled DFF output
setup_pass  out  1  1 = last edge captured successfully
setup_req  out  8  current setup requirement, combinational
cq_delay  out  16  clock-to-q estimate, combinational
rd_edge  in  1  readout select: 0 = rising-data table, 1 = falling-data table
rd_ck  in  2  readout clock slope index
rd_d  in  2  readout data slope index
rd_data  out  8  minimum passing margin at selected point; 255 = never passed

Behaviour:
- Reset (rst=1 at a clk edge):
  - q=0, setup_pass=0, all 18 table entries=255.
  - Reset overrides all other activity on that edge, including mid-sweep.
- Setup requirement (combinational):
  - Saturating 8-bit sum: setup_req = min(255, SU_BASE + (SLOPE[ck] >> CK_SHIFT) + (SLOPE[d] >> D_SHIFT)).
  - Select value 3 aliases index 2.
  - Intermediate sum is computed at 12 bits or more before saturation.
- Capture (each rising clk, rst=0):
  - pass = (setup_margin >= setup_req). Equality passes.
  - If pass: q <= din.
  - Else: q holds its previous value (failed capture is modelled as a hold, never X).
  - setup_pass <= pass.
  - The register update occurs at the same edge: latency 1 cycle from sampled inputs to q and setup_pass.
- Table update (same edge, rst=0, fin_test=0, pass=1, din != q_prev):
  - A transition actually captured is classified: edge = 0 if din=1 (rising), edge = 1 if din=0 (falling).
  - Entry [edge][ck][d] <= min(entry, setup_margin).
  - No update when din == q_prev (no transition to characterize) or when the capture fails.
- fin_test=1:
  - Table frozen.
  - q and setup_pass keep operating.
  - Readout remains valid.
- cq_delay = min(65535, CQ_BASE + (cap_load >> CAP_SHIFT) + (SLOPE[ck] >> CK_SHIFT)), combinational.
- Readout: rd_data is a combinational read of entry [rd_edge][rd_ck][rd_d], with index 3 aliasing to 2. A read and an update of the same entry in the same cycle return the pre-update value.
- Slope indices, cap_load and margin are sampled only at the capture edge; changes between edges have no effect.

Test Plan:
- Reset: rst=1 for 2 edges -> q=0, setup_pass=0, rd_data=255 at every index.
- Requirement: ck=0, d=0 -> setup_req = 30+0+1 = 31; ck=2, d=2 -> 30+124+248 saturates to 255.
- Boundary: ck=0, d=0, din 0->1:
  - margin=30 -> q stays 0, setup_pass=0, entry unchanged 255.
  - next edge margin=31 -> q=1, setup_pass=1, entry[0][0][0]=31.
- Sweep: ck=1, d=0, alternate din 1/0 with margin descending 100..0:
  - setup_req = 30+28+1 = 59.
  - entry[0][1][0]=59 and entry[1][1][0]=59.
  - q toggles only while margin >= 59.
- Freeze: fin_test=1, then a passing transition at margin 40 -> table unchanged, q still follows din.
- Load: cap_load=6073, ck=0 -> cq_delay = 400+189+0 = 589.
